uart_rx_9600: RTL and testbench

//  8N1 UART receiver; the receive end of the board's 9600-baud serial link.

---
 rtl/uart_rx_9600_pkg.sv | 30 +++
 rtl/uart_baud_tick.sv | 37 +++
 rtl/uart_rx_9600.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx_9600.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_9600_pkg.sv
// ----------------------------------------------------------------------------
// uart_rx_9600_pkg
// Shared definitions for the 9600-baud serial link: receiver state encoding,
// default oversampling ratio, baud divider computation and the parity check.
// Also intended for the companion transmitter and the freq9600 block.
// ----------------------------------------------------------------------------
package uart_rx_9600_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BRK    = 3'd5
   } rx_state_t;

   localparam int OVERSAMPLE_DEFAULT = 16;

   // Clocks per oversample tick, integer-truncated.
   function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
      return clk_freq / (baud * oversample);
   endfunction

   // Even parity over data plus parity bit: returns 1 when the check fails.
   function automatic logic even_parity_bad(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// ----------------------------------------------------------------------------
// uart_baud_tick
// Oversample tick generator: counts 0..DIV-1 and flags tick on DIV-1.
// Held at 0 while clr is high so the bit phase can be aligned to an event.
// Ports:
//   clk_in  in  system clock
//   rst     in  asynchronous reset, active high
//   clr     in  hold counter at 0
//   tick    out one-cycle pulse every DIV clocks
// ----------------------------------------------------------------------------
module uart_baud_tick #(
   parameter int DIV = 325
) (
   input  logic clk_in,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] count;

   // Divider counter, wraps at DIV-1.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr || (count == CW'(DIV - 1))) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

   assign tick = (count == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx_9600.sv
// ----------------------------------------------------------------------------
// uart_rx_9600
// 8N1 UART receiver with its own 16x oversampled baud enable. Delivers bytes
// over a valid/ready handshake and pulses frame_err / overrun / parity_err.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit between
// the data and stop bits (8E1); without it parity_err is constant 0.
// Ports:
//   clk_in      in   system clock
//   rst         in   asynchronous reset, active high
//   rx_in       in   serial line, idle high, asynchronous
//   rx_data     out  received byte, stable while rx_valid
//   rx_valid    out  byte available
//   rx_ready    in   consumer accepts (transfer on rx_valid & rx_ready)
//   frame_err   out  pulse: stop bit sampled low
//   overrun     out  pulse: byte completed while previous one unaccepted
//   parity_err  out  pulse: parity mismatch
// ----------------------------------------------------------------------------
module uart_rx_9600
   import uart_rx_9600_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic       rx_in,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       parity_err
);

   localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int SW  = $clog2(OVERSAMPLE);
   localparam logic [SW-1:0] SMP_HALF = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] SMP_LAST = SW'(OVERSAMPLE - 1);

   rx_state_t     state;
   logic          sync1;
   logic          rx_s;
   logic [SW-1:0] smp;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          tick;
   logic          par_ok;

   // Phase reference is the detected start edge: the divider sits at 0 in IDLE.
   uart_baud_tick #(.DIV(DIV)) u_tick (
      .clk_in (clk_in),
      .rst    (rst),
      .clr    (state == ST_IDLE),
      .tick   (tick)
   );

   // Two-flop synchroniser for the asynchronous line; idles high.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= rx_in;
         rx_s  <= sync1;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_bad;
   assign par_ok = !par_bad;
`else
   assign par_ok = 1'b1;
`endif

   // Receive state machine with registered handshake and error outputs.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         smp        <= '0;
         bit_idx    <= 3'd0;
         shift      <= 8'd0;
         rx_data    <= 8'd0;
         rx_valid   <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad    <= 1'b0;
`endif
      end else begin
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         parity_err <= 1'b0;
         if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
         case (state)
            ST_IDLE: begin
               if (!rx_s) begin
                  state <= ST_START;
                  smp   <= '0;
               end
            end
            ST_START: begin
               if (tick) begin
                  if (smp == SMP_HALF) begin
                     smp <= '0;
                     if (rx_s) begin
                        state <= ST_IDLE;   // glitch, not a start bit
                     end else begin
                        state   <= ST_DATA;
                        bit_idx <= 3'd0;
                     end
                  end else begin
                     smp <= smp + SW'(1);
                  end
               end
            end
            ST_DATA: begin
               if (tick) begin
                  if (smp == SMP_LAST) begin
                     smp   <= '0;
                     shift <= {rx_s, shift[7:1]};
                     if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state <= ST_PARITY;
`else
                        state <= ST_STOP;
`endif
                     end else begin
                        bit_idx <= bit_idx + 3'd1;
                     end
                  end else begin
                     smp <= smp + SW'(1);
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (tick) begin
                  if (smp == SMP_LAST) begin
                     smp     <= '0;
                     par_bad <= even_parity_bad(shift, rx_s);
                     state   <= ST_STOP;
                  end else begin
                     smp <= smp + SW'(1);
                  end
               end
            end
`endif
            ST_STOP: begin
               if (tick) begin
                  if (smp == SMP_LAST) begin
                     smp <= '0;
`ifdef UART_RX_PARITY_EN
                     parity_err <= par_bad;
`endif
                     if (rx_s) begin
                        state <= ST_IDLE;
                        if (par_ok) begin
                           // An accept in this same cycle frees the slot.
                           if (!rx_valid || rx_ready) begin
                              rx_data  <= shift;
                              rx_valid <= 1'b1;
                           end else begin
                              overrun <= 1'b1;
                           end
                        end
                     end else begin
                        frame_err <= 1'b1;
                        state     <= ST_BRK;
                     end
                  end else begin
                     smp <= smp + SW'(1);
                  end
               end
            end
            ST_BRK: begin
               // Held-low line: one frame_err only, wait for idle.
               if (rx_s) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_9600.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_9600
// Scoreboard bench: the stimulus pushes expected bytes into a queue, and a
// monitor pops and compares on each accepted transfer. Error pulses are
// counted by the monitor and compared against expected counts at checkpoints.
// CLK_FREQ=1_536_000, BAUD=9600 -> DIV=10, 160 clocks per bit.
// ----------------------------------------------------------------------------
module tb_uart_rx_9600;

   localparam int BIT_CLK = 160;

   logic       clk_in = 1'b0;
   logic       rst;
   logic       rx_in;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;
   logic       parity_err;

   int total = 0;
   int bad   = 0;
   int n_xfer = 0;
   int n_fe = 0, n_ov = 0, n_pe = 0;
   int exp_fe = 0, exp_ov = 0, exp_pe = 0;
   logic [7:0] exp_q[$];

   uart_rx_9600 #(
      .CLK_FREQ   (1_536_000),
      .BAUD       (9600),
      .OVERSAMPLE (16)
   ) dut (
      .clk_in     (clk_in),
      .rst        (rst),
      .rx_in      (rx_in),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .parity_err (parity_err)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic bitt(input logic b);
      rx_in = b;
      cycles(BIT_CLK);
   endtask

   // Start, 8 data bits LSB first, optional parity, stop; a low stop bit
   // is followed by low_hold extra low clocks before the line returns high.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                             input logic par_flip, input int low_hold);
      bitt(1'b0);
      for (int i = 0; i < 8; i++) bitt(d[i]);
`ifdef UART_RX_PARITY_EN
      bitt((^d) ^ par_flip);
`endif
      bitt(stop_bit);
      if (!stop_bit) cycles(low_hold);
      rx_in = 1'b1;
      cycles(200);
   endtask

   task automatic checkpoint(input string tag);
      chk({tag, "_frame_err"}, n_fe, exp_fe);
      chk({tag, "_overrun"}, n_ov, exp_ov);
      chk({tag, "_parity_err"}, n_pe, exp_pe);
      chk({tag, "_pending"}, exp_q.size(), 0);
   endtask

   // Monitor: compare each accepted byte against the scoreboard; count pulses.
   initial begin
      forever begin
         @(negedge clk_in);
         if (!rst) begin
            if (frame_err)  n_fe++;
            if (overrun)    n_ov++;
            if (parity_err) n_pe++;
            if (rx_valid && rx_ready) begin
               n_xfer++;
               if (exp_q.size() == 0) begin
                  chk("unexpected_byte", int'(rx_data), -1);
               end else begin
                  chk("rx_data", int'(rx_data), int'(exp_q.pop_front()));
               end
            end
         end
      end
   end

   initial begin
      int x0;
      rst      = 1'b1;
      rx_in    = 1'b1;
      rx_ready = 1'b1;
      cycles(5);
      chk("rst_rx_data", int'(rx_data), 0);
      chk("rst_rx_valid", int'(rx_valid), 0);
      chk("rst_pulses", int'({frame_err, overrun, parity_err}), 0);
      rst = 1'b0;
      cycles(20);

      // Plain byte with consumer ready
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, 1'b0, 0);
      chk("a5_valid_dropped", int'(rx_valid), 0);
      checkpoint("a5");

      // 60-clock glitch must be rejected
      x0 = n_xfer;
      rx_in = 1'b0;
      cycles(60);
      rx_in = 1'b1;
      cycles(300);
      chk("glitch_no_byte", n_xfer, x0);
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1, 1'b0, 0);
      checkpoint("glitch");

      // Bad stop bit followed by a 2000-clock break
      x0 = n_xfer;
      exp_fe++;
      send_frame(8'h55, 1'b0, 1'b0, 2000);
      chk("break_no_byte", n_xfer, x0);
      exp_q.push_back(8'h12);
      send_frame(8'h12, 1'b1, 1'b0, 0);
      checkpoint("break");

      // Overrun: consumer stalled across two frames
      rx_ready = 1'b0;
      exp_q.push_back(8'h01);
      send_frame(8'h01, 1'b1, 1'b0, 0);
      chk("stall_valid", int'(rx_valid), 1);
      exp_ov++;
      send_frame(8'h02, 1'b1, 1'b0, 0);
      chk("ovr_valid_held", int'(rx_valid), 1);
      chk("ovr_data_held", int'(rx_data), 8'h01);
      rx_ready = 1'b1;
      cycles(2);
      chk("ovr_valid_cleared", int'(rx_valid), 0);
      checkpoint("overrun");

      // Reset in the middle of the data bits of 0xFF
      rx_in = 1'b0;
      cycles(BIT_CLK);
      rx_in = 1'b1;
      cycles(3 * BIT_CLK + 40);
      rst = 1'b1;
      cycles(3);
      chk("midrst_rx_data", int'(rx_data), 0);
      chk("midrst_rx_valid", int'(rx_valid), 0);
      chk("midrst_pulses", int'({frame_err, overrun, parity_err}), 0);
      rst = 1'b0;
      cycles(6 * BIT_CLK);
      chk("midrst_no_byte", int'(rx_valid), 0);
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b1, 1'b0, 0);
      checkpoint("midrst");

`ifdef UART_RX_PARITY_EN
      // Even parity: 0x07 needs parity bit 1
      x0 = n_xfer;
      exp_pe++;
      send_frame(8'h07, 1'b1, 1'b1, 0);
      chk("par_bad_no_byte", n_xfer, x0);
      exp_q.push_back(8'h07);
      send_frame(8'h07, 1'b1, 1'b0, 0);
      checkpoint("parity");
`endif

      cycles(50);
      chk("final_pending", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
